// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the DLX fetch/data requesters, the arbiter and the shared memory port.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface mem_port_arbiter_if #(
  parameter int ADDRESS_SIZE = 32,
  parameter int WORD_SIZE    = 32
);
  logic                    ifReq;
  logic [ADDRESS_SIZE-1:0] ifAddr;
  logic                    ifReady;
  logic [WORD_SIZE-1:0]    ifData;

  logic                    dReq;
  logic                    dRnw;
  logic [ADDRESS_SIZE-1:0] dAddr;
  logic [WORD_SIZE-1:0]    dWdata;
  logic                    dReady;
  logic [WORD_SIZE-1:0]    dRdata;

  logic [ADDRESS_SIZE-1:0] memAddress;
  logic                    memEnable;
  logic                    memReadNotWrite;
  logic [WORD_SIZE-1:0]    memWdata;
  logic [WORD_SIZE-1:0]    memRdata;
  logic                    memReady;

  modport master (
    input  ifReq, ifAddr, dReq, dRnw, dAddr, dWdata, memRdata, memReady,
    output ifReady, ifData, dReady, dRdata,
           memAddress, memEnable, memReadNotWrite, memWdata
  );

  modport slave (
    output ifReq, ifAddr, dReq, dRnw, dAddr, dWdata, memRdata, memReady,
    input  ifReady, ifData, dReady, dRdata,
           memAddress, memEnable, memReadNotWrite, memWdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises DLX fetch and data accesses onto one memory port; data has priority,
// a grant-streak limit guarantees fetch progress and a watchdog aborts stuck accesses.
module mem_port_arbiter #(
  parameter int ADDRESS_SIZE   = 32,
  parameter int WORD_SIZE      = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_port_arbiter_if.master bus,
  output logic               busy_o,
  output logic               timeoutErr_o
);

  localparam int StreakW = $clog2(STARVE_LIMIT + 1);
  localparam int WdogW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(STARVE_LIMIT);
  localparam logic [WdogW-1:0]   WdogLast  = WdogW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [StreakW-1:0]      streak_q, streak_d;
  logic [WdogW-1:0]        wdog_q, wdog_d;
  logic [ADDRESS_SIZE-1:0] memAddr_q, memAddr_d;
  logic                    memEn_q, memEn_d;
  logic                    memRnw_q, memRnw_d;
  logic [WORD_SIZE-1:0]    memWdata_q, memWdata_d;
  logic                    ifReady_q, ifReady_d;
  logic                    dReady_q, dReady_d;
  logic [WORD_SIZE-1:0]    ifData_q, ifData_d;
  logic [WORD_SIZE-1:0]    dRdata_q, dRdata_d;
  logic                    busy_q, busy_d;
  logic                    timeout_q, timeout_d;

  logic                    dataGrant;
  logic                    fetchGrant;
  logic                    finish;
  logic [WORD_SIZE-1:0]    rdWord;

  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    wdog_d     = '0;
    memAddr_d  = memAddr_q;
    memEn_d    = memEn_q;
    memRnw_d   = memRnw_q;
    memWdata_d = memWdata_q;
    ifReady_d  = 1'b0;
    dReady_d   = 1'b0;
    ifData_d   = ifData_q;
    dRdata_d   = dRdata_q;
    timeout_d  = timeout_q;
    dataGrant  = 1'b0;
    fetchGrant = 1'b0;
    finish     = 1'b0;
    rdWord     = '0;

    case (state_q)
      IDLE: begin
        if (bus.dReq && !(bus.ifReq && streak_q == StreakMax)) begin
          dataGrant = 1'b1;
        end else if (bus.ifReq) begin
          fetchGrant = 1'b1;
        end
        if (dataGrant) begin
          state_d    = BUSY_D;
          memEn_d    = 1'b1;
          memAddr_d  = bus.dAddr;
          memRnw_d   = bus.dRnw;
          memWdata_d = bus.dWdata;
        end else if (fetchGrant) begin
          state_d   = BUSY_I;
          memEn_d   = 1'b1;
          memAddr_d = bus.ifAddr;
          memRnw_d  = 1'b1;
        end
      end
      BUSY_I, BUSY_D: begin
        // An aborted access completes like a normal one but returns a zero word.
        if (bus.memReady) begin
          finish = 1'b1;
          rdWord = bus.memRdata;
        end else if (wdog_q == WdogLast) begin
          finish    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
        if (finish) begin
          memEn_d = 1'b0;
          state_d = DONE;
          if (state_q == BUSY_I) begin
            ifReady_d = 1'b1;
            ifData_d  = rdWord;
          end else begin
            dReady_d = 1'b1;
            if (memRnw_q) begin
              dRdata_d = rdWord;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The streak only means something while a fetch is actually waiting.
    if (!bus.ifReq) begin
      streak_d = '0;
    end else if (dataGrant && streak_q != StreakMax) begin
      streak_d = streak_q + 1'b1;
    end else if (fetchGrant) begin
      streak_d = '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      wdog_q     <= '0;
      memAddr_q  <= '0;
      memEn_q    <= 1'b0;
      memRnw_q   <= 1'b1;
      memWdata_q <= '0;
      ifReady_q  <= 1'b0;
      dReady_q   <= 1'b0;
      ifData_q   <= '0;
      dRdata_q   <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      wdog_q     <= wdog_d;
      memAddr_q  <= memAddr_d;
      memEn_q    <= memEn_d;
      memRnw_q   <= memRnw_d;
      memWdata_q <= memWdata_d;
      ifReady_q  <= ifReady_d;
      dReady_q   <= dReady_d;
      ifData_q   <= ifData_d;
      dRdata_q   <= dRdata_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.memAddress      = memAddr_q;
  assign bus.memEnable       = memEn_q;
  assign bus.memReadNotWrite = memRnw_q;
  assign bus.memWdata        = memWdata_q;
  assign bus.ifReady         = ifReady_q;
  assign bus.ifData          = ifData_q;
  assign bus.dReady          = dReady_q;
  assign bus.dRdata          = dRdata_q;
  assign busy_o              = busy_q;
  assign timeoutErr_o        = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random
// traffic against a transaction-level model compared every cycle.
module tb_mem_port_arbiter;

  localparam int AS             = 32;
  localparam int WS             = 32;
  localparam int STARVE_LIMIT   = 4;
  localparam int TIMEOUT_CYCLES = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic timeoutErr;

  int nCompared = 0;
  int nMismatch = 0;

  mem_port_arbiter_if #(.ADDRESS_SIZE(AS), .WORD_SIZE(WS)) bus ();

  mem_port_arbiter #(
    .ADDRESS_SIZE  (AS),
    .WORD_SIZE     (WS),
    .STARVE_LIMIT  (STARVE_LIMIT),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .busy_o      (busy),
    .timeoutErr_o(timeoutErr)
  );

  always #5 clk = ~clk;

  // Memory model: ready after a configurable number of enable cycles, optional hang,
  // optional stray ready pulses while the port is idle.
  logic [WS-1:0] mem [0:255];
  int  memCnt      = 0;
  int  memDelayFix = 2;
  bit  memHangFix  = 1'b0;
  int  memDelayR   = 0;
  bit  memHangR    = 1'b0;
  bit  memSpurR    = 1'b0;
  bit  randMem     = 1'b0;
  int  effDelay;
  bit  effHang;
  bit  effSpur;

  assign effDelay = randMem ? memDelayR : memDelayFix;
  assign effHang  = randMem ? memHangR : memHangFix;
  assign effSpur  = randMem ? memSpurR : 1'b0;
  assign bus.memReady = bus.memEnable ? (!effHang && memCnt == effDelay) : effSpur;
  assign bus.memRdata = mem[bus.memAddress[7:0]];

  always @(posedge clk) begin
    if (bus.memEnable === 1'b1 && !bus.memReady) memCnt <= memCnt + 1;
    else memCnt <= 0;
    if (bus.memEnable === 1'b1 && bus.memReady && !bus.memReadNotWrite)
      mem[bus.memAddress[7:0]] <= bus.memWdata;
    if (randMem && bus.memEnable !== 1'b1) begin
      memDelayR <= $urandom_range(0, 3);
      memHangR  <= ($urandom_range(0, 11) == 0);
      memSpurR  <= $urandom_range(0, 1);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: at most one access in flight, a bubble after each completion.
  bit          mActive  = 1'b0;
  bit          mBubble  = 1'b0;
  bit          mWhoD    = 1'b0;
  int          mWait    = 0;
  int          mStreak  = 0;
  logic        eEnable  = 1'b0;
  logic        eRnw     = 1'b1;
  logic [31:0] eAddr    = '0;
  logic [31:0] eWdata   = '0;
  logic        eIfReady = 1'b0;
  logic        eDReady  = 1'b0;
  logic [31:0] eIfData  = '0;
  logic [31:0] eDRdata  = '0;
  logic        eBusy    = 1'b0;
  logic        eTimeout = 1'b0;

  task automatic stepModel();
    logic [31:0] word;
    bit          done;
    bit          fetchOwed;
    if (rst) begin
      mActive = 0; mBubble = 0; mWait = 0; mStreak = 0;
      eEnable = 0; eRnw = 1; eAddr = '0; eWdata = '0;
      eIfReady = 0; eDReady = 0; eIfData = '0; eDRdata = '0;
      eBusy = 0; eTimeout = 0;
      return;
    end
    eIfReady = 0;
    eDReady  = 0;
    done     = 0;
    word     = '0;
    if (mActive) begin
      if (bus.memReady) begin
        done = 1;
        word = bus.memRdata;
      end else if (mWait + 1 >= TIMEOUT_CYCLES) begin
        done     = 1;
        eTimeout = 1;
      end else begin
        mWait++;
      end
      if (done) begin
        mActive = 0;
        mBubble = 1;
        eEnable = 0;
        if (mWhoD) begin
          eDReady = 1;
          if (eRnw) eDRdata = word;
        end else begin
          eIfReady = 1;
          eIfData  = word;
        end
      end
    end else if (mBubble) begin
      mBubble = 0;
    end else begin
      fetchOwed = bus.ifReq && (mStreak >= STARVE_LIMIT);
      if (bus.dReq && !fetchOwed) begin
        mActive = 1; mWhoD = 1; mWait = 0; eEnable = 1;
        eAddr = bus.dAddr; eRnw = bus.dRnw; eWdata = bus.dWdata;
        if (bus.ifReq && mStreak < STARVE_LIMIT) mStreak++;
      end else if (bus.ifReq) begin
        mActive = 1; mWhoD = 0; mWait = 0; eEnable = 1;
        eAddr = bus.ifAddr; eRnw = 1;
        mStreak = 0;
      end
    end
    if (!bus.ifReq) mStreak = 0;
    eBusy = mActive || mBubble;
  endtask

  logic [7:0] grantLog [$];
  bit         logOn  = 1'b0;
  bit         prevEn = 1'b0;

  always @(negedge clk) begin
    checkOutput("memEnable", bus.memEnable, eEnable);
    checkOutput("memAddress", bus.memAddress, eAddr);
    checkOutput("memRnw", bus.memReadNotWrite, eRnw);
    checkOutput("memWdata", bus.memWdata, eWdata);
    checkOutput("ifReady", bus.ifReady, eIfReady);
    checkOutput("dReady", bus.dReady, eDReady);
    checkOutput("ifData", bus.ifData, eIfData);
    checkOutput("dRdata", bus.dRdata, eDRdata);
    checkOutput("busy", busy, eBusy);
    checkOutput("timeoutErr", timeoutErr, eTimeout);
    if (logOn && bus.memEnable === 1'b1 && !prevEn) grantLog.push_back(bus.memAddress[7:0]);
    prevEn = (bus.memEnable === 1'b1);
    stepModel();
  end

  task automatic applyStimulus(input bit isData, input bit rnw, input logic [31:0] addr,
                               input logic [31:0] wdata, input int dropAt,
                               output int latency, output int enCycles, output int pulses,
                               output logic firstRnw);
    logic rdy;
    latency  = -1;
    enCycles = 0;
    pulses   = 0;
    firstRnw = 1'bx;
    @(posedge clk); #1;
    if (isData) begin
      bus.dReq = 1; bus.dRnw = rnw; bus.dAddr = addr; bus.dWdata = wdata;
    end else begin
      bus.ifReq = 1; bus.ifAddr = addr;
    end
    for (int i = 1; i <= 60 && latency < 0; i++) begin
      @(posedge clk); #1;
      if (i == dropAt) begin
        if (isData) bus.dReq = 0; else bus.ifReq = 0;
      end
      if (bus.memEnable === 1'b1) begin
        enCycles++;
        if (enCycles == 1) firstRnw = bus.memReadNotWrite;
      end
      rdy = isData ? bus.dReady : bus.ifReady;
      if (rdy === 1'b1) begin
        latency = i;
        pulses++;
        if (isData) bus.dReq = 0; else bus.ifReq = 0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rdy = isData ? bus.dReady : bus.ifReady;
      if (rdy === 1'b1) pulses++;
    end
  endtask

  task automatic runRequester(input bit isData, input int count);
    bit   got;
    logic rdy;
    for (int n = 0; n < count; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1;
      if (isData) begin
        bus.dRnw   = $urandom_range(0, 1);
        bus.dAddr  = 32'($urandom_range(0, 255));
        bus.dWdata = $urandom;
        bus.dReq   = 1;
      end else begin
        bus.ifAddr = 32'($urandom_range(0, 255));
        bus.ifReq  = 1;
      end
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(posedge clk); #1;
        rdy = isData ? bus.dReady : bus.ifReady;
        if (rdy === 1'b1) got = 1;
      end
      checkOutput(isData ? "randDataServed" : "randFetchServed", 32'(got), 32'd1);
      if (isData) bus.dReq = 0; else bus.ifReq = 0;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL globalTimeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] global time limit reached");
  end

  initial begin
    int          lat;
    int          en;
    int          pulses;
    logic        fRnw;
    int          dCount;
    logic [7:0]  expOrder [10];
    expOrder = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h10, 8'h40, 8'h40, 8'h40, 8'h40, 8'h10};

    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 32'hDEADBEEF;
    bus.ifReq = 0; bus.ifAddr = '0;
    bus.dReq = 0; bus.dRnw = 1; bus.dAddr = '0; bus.dWdata = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstMemEnable", bus.memEnable, 1'b0);
    checkOutput("rstMemRnw", bus.memReadNotWrite, 1'b1);
    checkOutput("rstMemAddress", bus.memAddress, 32'h0);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstTimeout", timeoutErr, 1'b0);
    rst = 0;

    $display("[TB] T1 fetch only");
    applyStimulus(0, 1, 32'h10, '0, 0, lat, en, pulses, fRnw);
    checkOutput("t1Latency", lat, 4);
    checkOutput("t1EnableCycles", en, 3);
    checkOutput("t1Pulses", pulses, 1);
    checkOutput("t1IfData", bus.ifData, 32'hDEADBEEF);

    $display("[TB] T2 write then read");
    applyStimulus(1, 0, 32'h40, 32'h12345678, 0, lat, en, pulses, fRnw);
    checkOutput("t2WrRnw", fRnw, 1'b0);
    checkOutput("t2WrLatency", lat, 4);
    checkOutput("t2WrRdataHeld", bus.dRdata, 32'h0);
    applyStimulus(1, 1, 32'h40, '0, 0, lat, en, pulses, fRnw);
    checkOutput("t2RdRnw", fRnw, 1'b1);
    checkOutput("t2RdData", bus.dRdata, 32'h12345678);
    checkOutput("t2IfDataKept", bus.ifData, 32'hDEADBEEF);

    $display("[TB] T3 both requests held");
    grantLog.delete();
    logOn = 1;
    @(posedge clk); #1;
    bus.ifReq = 1; bus.ifAddr = 32'h10;
    bus.dReq = 1; bus.dRnw = 1; bus.dAddr = 32'h40;
    for (int i = 0; i < 200 && grantLog.size() < 10; i++) @(posedge clk);
    #1;
    bus.ifReq = 0; bus.dReq = 0; logOn = 0;
    checkOutput("t3GrantCount", grantLog.size(), 10);
    for (int i = 0; i < 10; i++)
      if (i < grantLog.size()) checkOutput($sformatf("t3Grant%0d", i), grantLog[i], expOrder[i]);
    repeat (12) @(posedge clk);

    $display("[TB] T4 memory hang");
    memHangFix = 1;
    applyStimulus(1, 1, 32'h40, '0, 0, lat, en, pulses, fRnw);
    checkOutput("t4EnableCycles", en, 8);
    checkOutput("t4Latency", lat, 9);
    checkOutput("t4Rdata", bus.dRdata, 32'h0);
    checkOutput("t4TimeoutErr", timeoutErr, 1'b1);
    memHangFix = 0;
    applyStimulus(1, 1, 32'h40, '0, 0, lat, en, pulses, fRnw);
    checkOutput("t4NextLatency", lat, 4);
    checkOutput("t4NextRdata", bus.dRdata, 32'h12345678);
    checkOutput("t4Sticky", timeoutErr, 1'b1);

    $display("[TB] T5 reset during data access");
    @(posedge clk); #1;
    bus.dReq = 1; bus.dRnw = 1; bus.dAddr = 32'h40;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t5BusyBefore", busy, 1'b1);
    rst = 1;
    @(posedge clk); #1;
    checkOutput("t5MemEnable", bus.memEnable, 1'b0);
    checkOutput("t5Busy", busy, 1'b0);
    checkOutput("t5DReady", bus.dReady, 1'b0);
    checkOutput("t5DRdata", bus.dRdata, 32'h0);
    checkOutput("t5IfData", bus.ifData, 32'h0);
    checkOutput("t5Timeout", timeoutErr, 1'b0);
    checkOutput("t5MemAddress", bus.memAddress, 32'h0);
    rst = 0;
    bus.dReq = 0;
    dCount = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.dReady === 1'b1) dCount++;
    end
    checkOutput("t5NoDReady", dCount, 0);
    applyStimulus(0, 1, 32'h10, '0, 0, lat, en, pulses, fRnw);
    checkOutput("t5FetchLatency", lat, 4);
    checkOutput("t5FetchData", bus.ifData, 32'hDEADBEEF);

    $display("[TB] T6 fetch request dropped mid-access");
    applyStimulus(0, 1, 32'h10, '0, 2, lat, en, pulses, fRnw);
    checkOutput("t6Latency", lat, 4);
    checkOutput("t6Pulses", pulses, 1);

    $display("[TB] random traffic");
    randMem = 1;
    fork
      runRequester(0, 60);
      runRequester(1, 60);
    join
    randMem = 0;
    repeat (20) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
